branch_redirect_ctrl: RTL

//  Sequences fetch-stage static branch predictions against execute-stage resolution in the PQR5 core.

---
 rtl/branch_redirect_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/branch_redirect_ctrl.sv
// Branch redirect control: in-order FIFO of fetch predictions checked
// against EXU resolution; issues redirect + timed flush on mispredict.
`ifndef XLEN
`define XLEN 32
`endif

module branch_redirect_ctrl #(
  parameter int DEPTH     = 4,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic                     i_pred_valid,
  input  logic                     i_pred_taken,
  input  logic [`XLEN-1:0]         i_pred_pc,
  input  logic [`XLEN-1:0]         i_pred_target,
  output logic                     o_pred_ready,
  input  logic                     i_res_valid,
  input  logic                     i_res_taken,
  input  logic [`XLEN-1:0]         i_res_target,
  output logic                     o_redirect,
  output logic [`XLEN-1:0]         o_redirect_pc,
  output logic                     o_flush,
  output logic [$clog2(DEPTH):0]   o_inflight,
  output logic [CNT_W-1:0]         o_branch_cnt,
  output logic [CNT_W-1:0]         o_mispred_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  typedef enum logic {
    RUN,
    FLUSH
  } state_t;

  state_t           state_q, state_d;
  logic [FW-1:0]    fcnt_q, fcnt_d;

  logic [PW-1:0]    wr_q, rd_q;
  logic [PW:0]      cnt_q;

  logic             taken_mem [DEPTH];
  logic [`XLEN-1:0] pc_mem    [DEPTH];
  logic [`XLEN-1:0] tgt_mem   [DEPTH];

  logic             full, empty;
  logic             push, pop, mispred;
  logic             head_taken;
  logic [`XLEN-1:0] head_pc, head_tgt;
  logic [`XLEN-1:0] redir_pc;
  logic [CNT_W-1:0] cnt_max;

  assign cnt_max    = '1;
  assign full       = (cnt_q == (PW+1)'(DEPTH));
  assign empty      = (cnt_q == '0);
  assign head_taken = taken_mem[rd_q];
  assign head_pc    = pc_mem[rd_q];
  assign head_tgt   = tgt_mem[rd_q];

  assign o_pred_ready = (state_q == RUN) & ~full;
  assign push         = i_pred_valid & o_pred_ready;
  assign pop          = i_res_valid & ~empty & (state_q == RUN);
  assign mispred      = pop &
                        ((head_taken != i_res_taken) |
                         (i_res_taken & (head_tgt != i_res_target)));
  assign redir_pc     = i_res_taken ? i_res_target
                                    : head_pc + `XLEN'(4);

  assign o_flush    = (state_q == FLUSH);
  assign o_inflight = cnt_q;

  // Next state: enter FLUSH on mispredict, count down, then resume
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      RUN: begin
        if (mispred) begin
          state_d = FLUSH;
          fcnt_d  = FW'(FLUSH_CYC - 1);
        end
      end
      FLUSH: begin
        if (fcnt_q == '0) state_d = RUN;
        else              fcnt_d  = fcnt_q - 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  // State and flush-length register
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Registered redirect pulse; PC holds between pulses
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      o_redirect    <= 1'b0;
      o_redirect_pc <= '0;
    end else begin
      o_redirect <= mispred;
      if (mispred) o_redirect_pc <= redir_pc;
    end
  end

  // FIFO pointers/occupancy; a mispredict wipes wrong-path entries
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (mispred) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // FIFO payload storage
  always_ff @(posedge clk) begin
    if (push) begin
      taken_mem[wr_q] <= i_pred_taken;
      pc_mem[wr_q]    <= i_pred_pc;
      tgt_mem[wr_q]   <= i_pred_target;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      o_branch_cnt  <= '0;
      o_mispred_cnt <= '0;
    end else begin
      if (pop && o_branch_cnt != cnt_max)
        o_branch_cnt <= o_branch_cnt + 1'b1;
      if (mispred && o_mispred_cnt != cnt_max)
        o_mispred_cnt <= o_mispred_cnt + 1'b1;
    end
  end

endmodule
